// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Only writer of the register file write port. Two producers share it:
//   - ALU results: single cycle, never stalled, always win the port.
//   - Memory-load results: variable latency, buffered in an in-order FIFO
//     of DEPTH entries, drained whenever the ALU leaves the port idle.
// The ALU result is always younger than any queued load. An accepted ALU
// write to register r therefore kills every queued load that targets r.
// Killed entries still drain in order, but they produce no write.
// Register 15 is not writable. Writes to it from either source are
// discarded, and r15_drop pulses for one cycle.
//
// Handshake (memory side): mem_valid and mem_ready follow strict
// valid/ready rules. A transfer happens at the rising edge where both are
// 1. mem_ready depends only on registered state (count < DEPTH), so it
// never looks at mem_valid, and a pop in that cycle does not free a slot
// for a same-cycle enqueue. Data that is offered while mem_ready is 0 is
// not taken. The producer must hold it and offer it again.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   alu_valid/dest/data ALU result for this cycle
//   mem_valid/dest/data load result offered to the FIFO
//   mem_ready           FIFO has a free slot
//   rf_write_enable     registered write strobe to the register file
//   rf_dest, rf_data    registered write address/data; held when idle
//   pending_mask        bit r set while a live queued load targets r
//   r15_drop            registered one-cycle pulse: a write to R15 was discarded

module writeback_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [3:0]       alu_dest,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    input  logic [3:0]       mem_dest,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_ready,
    output logic             rf_write_enable,
    output logic [3:0]       rf_dest,
    output logic [WIDTH-1:0] rf_data,
    output logic [15:0]      pending_mask,
    output logic             r15_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [3:0]  R15     = 4'd15;

    // FIFO storage. A live bit is set only for an occupied, not-killed
    // entry, so pending_mask and the head decision can use it directly.
    logic [DEPTH-1:0] ent_live;
    logic [3:0]       ent_dest [DEPTH];
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;

    logic mem_xfer;
    logic alu_write;
    logic enq;
    logic pop;
    logic head_write;
    logic enq_live;

    assign mem_ready = (count < DEPTH_C);
    assign mem_xfer  = mem_valid && mem_ready;
    assign alu_write = alu_valid && (alu_dest != R15);
    assign enq       = mem_xfer && (mem_dest != R15);

    // A load that arrives in the same cycle as an ALU write to the same
    // register is already stale. It still takes a slot, but it is stored
    // as killed.
    assign enq_live  = !(alu_write && (alu_dest == mem_dest));

    // The head pops whenever the FIFO is non-empty, except when it is live
    // and the ALU owns the port. A killed head drains even under ALU
    // traffic, because popping it needs no write-port cycle.
    assign pop        = (count != '0) && !(alu_write && ent_live[head]);
    assign head_write = pop && ent_live[head];

    // Control state: live bits, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_live <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (alu_write) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_dest[i] == alu_dest) begin
                        ent_live[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                ent_live[head] <= 1'b0;
                head           <= head + AW'(1);
            end
            // The tail slot is never occupied when enq is 1, so this
            // assignment cannot collide with the kill or the pop above.
            if (enq) begin
                ent_live[tail] <= enq_live;
                tail           <= tail + AW'(1);
            end
            count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
        end
    end

    // Payload storage. It has no reset, because the live bits alone decide
    // whether an entry has any effect.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_dest[tail] <= mem_dest;
            ent_data[tail] <= mem_data;
        end
    end

    // Registered write port and the R15 discard pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_write_enable <= 1'b0;
            rf_dest         <= '0;
            rf_data         <= '0;
            r15_drop        <= 1'b0;
        end else begin
            // A single pulse, even when both sources target R15.
            r15_drop <= (alu_valid && (alu_dest == R15)) ||
                        (mem_xfer && (mem_dest == R15));
            if (alu_write) begin
                rf_write_enable <= 1'b1;
                rf_dest         <= alu_dest;
                rf_data         <= alu_data;
            end else if (head_write) begin
                rf_write_enable <= 1'b1;
                rf_dest         <= ent_dest[head];
                rf_data         <= ent_data[head];
            end else begin
                rf_write_enable <= 1'b0;
            end
        end
    end

    // Registers that still have a queued, live load.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live[i]) begin
                pending_mask[ent_dest[i]] = 1'b1;
            end
        end
        pending_mask[15] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter.
// Each task below covers one feature. The random task checks the DUT
// against a queue-based model of the write-port rules.

module tb_writeback_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic             live;
        logic [3:0]       dest;
        logic [WIDTH-1:0] data;
    } ent_t;

    logic             clk;
    logic             reset;
    logic             alu_valid;
    logic [3:0]       alu_dest;
    logic [WIDTH-1:0] alu_data;
    logic             mem_valid;
    logic [3:0]       mem_dest;
    logic [WIDTH-1:0] mem_data;
    logic             mem_ready;
    logic             rf_write_enable;
    logic [3:0]       rf_dest;
    logic [WIDTH-1:0] rf_data;
    logic [15:0]      pending_mask;
    logic             r15_drop;

    int vectors;
    int miscompares;

    // Reference model state.
    ent_t             exp_q[$];
    logic             m_we;
    logic [3:0]       m_dest;
    logic [WIDTH-1:0] m_data;
    logic             m_drop;

    writeback_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_dest        (alu_dest),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_dest        (mem_dest),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .rf_write_enable (rf_write_enable),
        .rf_dest         (rf_dest),
        .rf_data         (rf_data),
        .pending_mask    (pending_mask),
        .r15_drop        (r15_drop)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move past the next rising edge. Inputs change here, and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alu_valid = 1'b0; alu_dest = 4'd0; alu_data = '0;
        mem_valid = 1'b0; mem_dest = 4'd0; mem_data = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_alu(input logic v, input logic [3:0] d, input logic [WIDTH-1:0] x);
        alu_valid = v; alu_dest = d; alu_data = x;
    endtask

    task automatic drive_mem(input logic v, input logic [3:0] d, input logic [WIDTH-1:0] x);
        mem_valid = v; mem_dest = d; mem_data = x;
    endtask

    // ---------------- reference model ----------------
    // Applies the write-port rules for the inputs present at this edge.
    task automatic model_step();
        ent_t h;
        ent_t e;
        bit   aw;
        bit   xfer;
        aw   = alu_valid && (alu_dest != 4'd15);
        xfer = mem_valid && (exp_q.size() < DEPTH);
        m_drop = (alu_valid && alu_dest == 4'd15) || (xfer && mem_dest == 4'd15);
        m_we = 1'b0;
        if (aw) begin
            m_we = 1'b1; m_dest = alu_dest; m_data = alu_data;
            if (exp_q.size() > 0 && !exp_q[0].live) h = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            h = exp_q.pop_front();
            if (h.live) begin
                m_we = 1'b1; m_dest = h.dest; m_data = h.data;
            end
        end
        if (aw) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].dest == alu_dest) begin
                    e = exp_q[i]; e.live = 1'b0; exp_q[i] = e;
                end
            end
        end
        if (xfer && mem_dest != 4'd15) begin
            e.live = !(aw && mem_dest == alu_dest);
            e.dest = mem_dest;
            e.data = mem_data;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        foreach (exp_q[i]) if (exp_q[i].live) m[exp_q[i].dest] = 1'b1;
        return m;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), WIDTH'($urandom));
            drive_mem(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), WIDTH'($urandom));
            tick();
            vectors++;
            if ({rf_write_enable, rf_dest, rf_data, r15_drop, pending_mask, mem_ready} !==
                {1'b0, 4'd0, 32'd0, 1'b0, 16'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL reset_hold: we=%0b dest=%0d data=%h drop=%0b mask=%h ready=%0b want all 0, ready=1",
                         rf_write_enable, rf_dest, rf_data, r15_drop, pending_mask, mem_ready);
            end
        end
        set_idle();
        reset = 1'b1;
    endtask

    task automatic test_alu_only();
        do_reset();
        drive_alu(1'b1, 4'd3, 32'h0000_00A5);
        tick();
        vectors++;
        if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, 4'd3, 32'hA5}) begin
            miscompares++;
            $display("FAIL alu_write: got we=%0b dest=%0d data=%h want 1/3/a5", rf_write_enable, rf_dest, rf_data);
        end
        set_idle();
        tick();
        vectors++;
        if ({rf_write_enable, rf_dest, rf_data} !== {1'b0, 4'd3, 32'hA5}) begin
            miscompares++;
            $display("FAIL alu_idle_hold: got we=%0b dest=%0d data=%h want 0/3/a5", rf_write_enable, rf_dest, rf_data);
        end
    endtask

    task automatic test_load_full();
        logic [3:0] ds [4];
        ds = '{4'd1, 4'd2, 4'd4, 4'd5};
        do_reset();
        drive_alu(1'b1, 4'd10, 32'hDEAD_0000);
        for (int i = 0; i < 4; i++) begin
            drive_mem(1'b1, ds[i], 32'h100 + 32'(ds[i]));
            tick();
        end
        vectors++;
        if ({mem_ready, pending_mask} !== {1'b0, 16'h0036}) begin
            miscompares++;
            $display("FAIL full: ready=%0b mask=%h want 0/0036", mem_ready, pending_mask);
        end
        set_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, ds[i], 32'h100 + 32'(ds[i])}) begin
                miscompares++;
                $display("FAIL drain_%0d: got we=%0b dest=%0d data=%h want dest=%0d",
                         i, rf_write_enable, rf_dest, rf_data, ds[i]);
            end
            if (i == 0) begin
                vectors++;
                if (mem_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_pop: got %0b want 1", mem_ready);
                end
            end
        end
        tick();
        vectors++;
        if ({rf_write_enable, pending_mask} !== {1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL drain_end: we=%0b mask=%h want 0/0", rf_write_enable, pending_mask);
        end
    endtask

    task automatic test_kill();
        do_reset();
        drive_mem(1'b1, 4'd7, 32'h11);
        tick();
        vectors++;
        if ({rf_write_enable, pending_mask} !== {1'b0, 16'h0080}) begin
            miscompares++;
            $display("FAIL kill_enq: we=%0b mask=%h want 0/0080", rf_write_enable, pending_mask);
        end
        set_idle();
        drive_alu(1'b1, 4'd7, 32'h22);
        tick();
        vectors++;
        if ({rf_write_enable, rf_dest, rf_data, pending_mask} !== {1'b1, 4'd7, 32'h22, 16'h0}) begin
            miscompares++;
            $display("FAIL kill_alu: we=%0b dest=%0d data=%h mask=%h want 1/7/22/0000",
                     rf_write_enable, rf_dest, rf_data, pending_mask);
        end
        set_idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({rf_write_enable, rf_dest, rf_data} !== {1'b0, 4'd7, 32'h22}) begin
                miscompares++;
                $display("FAIL kill_silent_%0d: we=%0b dest=%0d data=%h want 0/7/22",
                         i, rf_write_enable, rf_dest, rf_data);
            end
        end
    endtask

    task automatic test_same_dest();
        do_reset();
        drive_alu(1'b1, 4'd10, 32'h5);
        for (int i = 1; i <= 3; i++) begin
            drive_mem(1'b1, 4'(i), 32'h200 + 32'(i));
            tick();
        end
        drive_alu(1'b1, 4'd9, 32'hAAA);
        drive_mem(1'b1, 4'd9, 32'hBBB);
        tick();
        vectors++;
        if ({rf_write_enable, rf_dest, rf_data, mem_ready, pending_mask} !==
            {1'b1, 4'd9, 32'hAAA, 1'b0, 16'h000E}) begin
            miscompares++;
            $display("FAIL same_dest: we=%0b dest=%0d data=%h ready=%0b mask=%h want 1/9/aaa/0/000e",
                     rf_write_enable, rf_dest, rf_data, mem_ready, pending_mask);
        end
        set_idle();
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, 4'(i), 32'h200 + 32'(i)}) begin
                miscompares++;
                $display("FAIL same_dest_drain_%0d: we=%0b dest=%0d data=%h", i, rf_write_enable, rf_dest, rf_data);
            end
        end
        tick();
        vectors++;
        if ({rf_write_enable, pending_mask, mem_ready} !== {1'b0, 16'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL same_dest_killed: we=%0b mask=%h ready=%0b want 0/0/1",
                     rf_write_enable, pending_mask, mem_ready);
        end
    endtask

    task automatic test_r15();
        do_reset();
        drive_alu(1'b1, 4'd15, 32'h77);
        tick();
        vectors++;
        if ({rf_write_enable, r15_drop} !== 2'b01) begin
            miscompares++;
            $display("FAIL r15_alu: we=%0b drop=%0b want 0/1", rf_write_enable, r15_drop);
        end
        set_idle();
        drive_mem(1'b1, 4'd15, 32'h88);
        tick();
        vectors++;
        if ({rf_write_enable, r15_drop, mem_ready, pending_mask} !== {1'b0, 1'b1, 1'b1, 16'h0}) begin
            miscompares++;
            $display("FAIL r15_mem: we=%0b drop=%0b ready=%0b mask=%h want 0/1/1/0",
                     rf_write_enable, r15_drop, mem_ready, pending_mask);
        end
        drive_alu(1'b1, 4'd15, 32'h99);
        tick();
        set_idle();
        vectors++;
        if ({rf_write_enable, r15_drop} !== 2'b01) begin
            miscompares++;
            $display("FAIL r15_both: we=%0b drop=%0b want 0/1", rf_write_enable, r15_drop);
        end
        tick();
        vectors++;
        if ({rf_write_enable, r15_drop} !== 2'b00) begin
            miscompares++;
            $display("FAIL r15_single_pulse: we=%0b drop=%0b want 0/0", rf_write_enable, r15_drop);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_alu(1'b1, 4'd10, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            drive_mem(1'b1, 4'(i), 32'h300 + 32'(i));
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({mem_ready, pending_mask, rf_write_enable} !== {1'b1, 16'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: ready=%0b mask=%h we=%0b want 1/0/0", mem_ready, pending_mask, rf_write_enable);
        end
        set_idle();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (rf_write_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_write_%0d: we=%0b want 0", i, rf_write_enable);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_mask;
        logic        exp_ready;
        do_reset();
        exp_q.delete();
        m_we = 1'b0; m_dest = '0; m_data = '0; m_drop = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive_alu(1'($urandom_range(0, 99) < 45),
                      ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
                      WIDTH'($urandom));
            drive_mem(1'($urandom_range(0, 99) < 60),
                      ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
                      WIDTH'($urandom));
            @(posedge clk);
            model_step();
            #1;
            exp_mask  = model_mask();
            exp_ready = (exp_q.size() < DEPTH);
            vectors++;
            if ({rf_write_enable, rf_dest, rf_data} !== {m_we, m_dest, m_data}) begin
                miscompares++;
                $display("FAIL rand_rf c=%0d: got %0b/%0d/%h want %0b/%0d/%h",
                         c, rf_write_enable, rf_dest, rf_data, m_we, m_dest, m_data);
            end
            vectors++;
            if ({r15_drop, pending_mask, mem_ready} !== {m_drop, exp_mask, exp_ready}) begin
                miscompares++;
                $display("FAIL rand_status c=%0d: drop=%0b mask=%h ready=%0b want %0b/%h/%0b",
                         c, r15_drop, pending_mask, mem_ready, m_drop, exp_mask, exp_ready);
            end
        end
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        set_idle();
        #2;
        test_reset();
        test_alu_only();
        test_load_full();
        test_kill();
        test_same_dest();
        test_r15();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
